snitch_icache_miss_tracker: RTL and testbench

- Sits directly upstream of the cache-line refiller. Accepts line misses from the lookup stage, coalesces misses to the same line, and allocates one pending-table entry per outstanding refill; the entry index is the refill ID.
- Consumes refill responses, issues the cache-line write, and returns data to every waiting fetch port at once via a port mask.

---
 rtl/snitch_icache_pkg.sv | 29 ++
 rtl/snitch_icache_miss_tracker_lzc.sv | 33 +++
 rtl/snitch_icache_miss_tracker.sv | 156 +++++++++++++++
 tb/tb_snitch_icache_miss_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared types for the instruction cache.
// config_t carries the geometry of one cache instance. Fields are 32-bit
// unsigned so that widths can be derived directly in parameter expressions.
// idx_width() gives a safe index width of at least one bit.
package snitch_icache_pkg;

    typedef struct packed {
        int unsigned FETCH_AW;
        int unsigned LINE_WIDTH;
        int unsigned LINE_ALIGN;
        int unsigned PENDING_SIZE;
        int unsigned PENDING_IW;
        int unsigned NR_FETCH_PORTS;
    } config_t;

    localparam config_t DEFAULT_CFG = '{
        FETCH_AW:       32'd32,
        LINE_WIDTH:     32'd128,
        LINE_ALIGN:     32'd4,
        PENDING_SIZE:   32'd2,
        PENDING_IW:     32'd1,
        NR_FETCH_PORTS: 32'd4
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/snitch_icache_miss_tracker_lzc.sv
// Lowest-set-bit finder used to pick the free pending-table slot.
// Ports:
//   in_i    - candidate vector (bit set = slot available)
//   cnt_o   - index of the lowest set bit (0 when none is set)
//   empty_o - no bit set
module snitch_icache_miss_tracker_lzc #(
    parameter int unsigned WIDTH = 32'd2,
    parameter int unsigned IW    = 32'd1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IW-1:0]    cnt_o,
    output logic             empty_o
);

    logic found_s;

    // Priority scan from bit 0 upwards; the first set bit wins.
    always_comb begin
        cnt_o   = '0;
        found_s = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (!found_s && in_i[i]) begin
                cnt_o   = IW'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

// File: rtl/snitch_icache_miss_tracker.sv
// Miss tracker between the instruction-cache lookup stage and the line refiller.
// Coalesces misses to the same line into one pending-table entry (entry index =
// refill ID), issues refill requests for new lines and bypass fetches, and on a
// refill response writes the line into the cache while answering every waiting
// fetch port at once through a port mask.
// Ports:
//   in_*          - miss from the lookup stage (in_id_i is one-hot port)
//   refill_req_*  - refill request to the refiller
//   refill_rsp_*  - refill response from the refiller
//   write_*       - cache-line write (suppressed for bypass responses)
//   out_rsp_*     - fetch response, out_rsp_id_o is the mask of waiting ports
module snitch_icache_miss_tracker
    import snitch_icache_pkg::*;
#(
    parameter config_t CFG = DEFAULT_CFG
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [CFG.FETCH_AW-1:0]               in_addr_i,
    input  logic [CFG.NR_FETCH_PORTS-1:0]         in_id_i,
    input  logic                                  in_bypass_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    output logic [CFG.FETCH_AW-1:0]               refill_req_addr_o,
    output logic [CFG.PENDING_IW-1:0]             refill_req_id_o,
    output logic                                  refill_req_bypass_o,
    output logic                                  refill_req_valid_o,
    input  logic                                  refill_req_ready_i,
    input  logic [CFG.LINE_WIDTH-1:0]             refill_rsp_data_i,
    input  logic                                  refill_rsp_error_i,
    input  logic [CFG.PENDING_IW-1:0]             refill_rsp_id_i,
    input  logic                                  refill_rsp_bypass_i,
    input  logic                                  refill_rsp_valid_i,
    output logic                                  refill_rsp_ready_o,
    output logic [CFG.FETCH_AW-CFG.LINE_ALIGN-1:0] write_addr_o,
    output logic [CFG.LINE_WIDTH-1:0]             write_data_o,
    output logic                                  write_error_o,
    output logic                                  write_valid_o,
    input  logic                                  write_ready_i,
    output logic [CFG.LINE_WIDTH-1:0]             out_rsp_data_o,
    output logic                                  out_rsp_error_o,
    output logic [CFG.NR_FETCH_PORTS-1:0]         out_rsp_id_o,
    output logic                                  out_rsp_valid_o,
    input  logic                                  out_rsp_ready_i
);

    localparam int unsigned AW  = CFG.FETCH_AW;
    localparam int unsigned LA  = CFG.LINE_ALIGN;
    localparam int unsigned LAW = CFG.FETCH_AW - CFG.LINE_ALIGN;
    localparam int unsigned PS  = CFG.PENDING_SIZE;
    localparam int unsigned IW  = CFG.PENDING_IW;
    localparam int unsigned NP  = CFG.NR_FETCH_PORTS;

    typedef struct packed {
        logic           valid;
        logic           bypass;
        logic [LAW-1:0] line_addr;
        logic [NP-1:0]  port_mask;
    } pending_entry_t;

    pending_entry_t table_q [PS];
    pending_entry_t table_d [PS];

    logic [LAW-1:0] in_line_s;
    logic           rsp_hs_s;
    logic [PS-1:0]  freeing_s;
    logic [PS-1:0]  hit_vec_s;
    logic [PS-1:0]  free_vec_s;
    logic           hit_s;
    logic [IW-1:0]  free_idx_s;
    logic           no_free_s;
    logic           alloc_s;

    assign in_line_s = in_addr_i[AW-1:LA];

    // Response stage: write and port response fire together or not at all.
    assign refill_rsp_ready_o = out_rsp_ready_i & (refill_rsp_bypass_i | write_ready_i);
    assign write_valid_o      = refill_rsp_valid_i & ~refill_rsp_bypass_i & out_rsp_ready_i;
    assign out_rsp_valid_o    = refill_rsp_valid_i & (refill_rsp_bypass_i | write_ready_i);
    assign rsp_hs_s           = refill_rsp_valid_i & refill_rsp_ready_o;

    assign write_addr_o    = table_q[refill_rsp_id_i].line_addr;
    assign write_data_o    = refill_rsp_data_i;
    assign write_error_o   = refill_rsp_error_i;
    assign out_rsp_data_o  = refill_rsp_data_i;
    assign out_rsp_error_o = refill_rsp_error_i;
    assign out_rsp_id_o    = table_q[refill_rsp_id_i].port_mask;

    // Per-entry match and availability; an entry retiring this cycle is neither.
    always_comb begin
        freeing_s  = '0;
        hit_vec_s  = '0;
        free_vec_s = '0;
        for (int i = 0; i < int'(PS); i++) begin
            freeing_s[i]  = rsp_hs_s & (refill_rsp_id_i == IW'(i));
            hit_vec_s[i]  = table_q[i].valid & ~table_q[i].bypass
                          & (table_q[i].line_addr == in_line_s) & ~freeing_s[i];
            free_vec_s[i] = ~table_q[i].valid & ~freeing_s[i];
        end
    end

    snitch_icache_miss_tracker_lzc #(
        .WIDTH (PS),
        .IW    (IW)
    ) i_free_lzc (
        .in_i    (free_vec_s),
        .cnt_o   (free_idx_s),
        .empty_o (no_free_s)
    );

    // Bypass fetches never coalesce, so they always need a fresh entry.
    assign hit_s               = in_valid_i & ~in_bypass_i & (|hit_vec_s);
    assign refill_req_valid_o  = in_valid_i & ~hit_s & ~no_free_s;
    assign refill_req_id_o     = free_idx_s;
    assign refill_req_bypass_o = in_bypass_i;
    assign refill_req_addr_o   = in_bypass_i ? in_addr_i : {in_line_s, {LA{1'b0}}};
    assign in_ready_o          = hit_s | (~no_free_s & refill_req_ready_i);
    assign alloc_s             = refill_req_valid_o & refill_req_ready_i;

    // Next table state: retire, allocate, or merge the requesting port.
    always_comb begin
        for (int i = 0; i < int'(PS); i++) begin
            if (freeing_s[i]) begin
                table_d[i] = '0;
            end else if (alloc_s && (free_idx_s == IW'(i))) begin
                table_d[i] = '{valid: 1'b1, bypass: in_bypass_i,
                               line_addr: in_line_s, port_mask: in_id_i};
            end else if (hit_s && hit_vec_s[i]) begin
                table_d[i]           = table_q[i];
                table_d[i].port_mask = table_q[i].port_mask | in_id_i;
            end else begin
                table_d[i] = table_q[i];
            end
        end
    end

    // Pending-table registers; reset drops every outstanding entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(PS); i++) begin
                table_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(PS); i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    // A refill response must always refer to an outstanding entry.
    rsp_for_valid_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
        refill_rsp_valid_i |-> table_q[refill_rsp_id_i].valid);
`endif

endmodule

// File: tb/tb_snitch_icache_miss_tracker.sv
module tb_snitch_icache_miss_tracker;
    import snitch_icache_pkg::*;

    localparam config_t TB_CFG = '{
        FETCH_AW: 32'd32, LINE_WIDTH: 32'd128, LINE_ALIGN: 32'd4,
        PENDING_SIZE: 32'd2, PENDING_IW: 32'd1, NR_FETCH_PORTS: 32'd4
    };

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_addr_i;
    logic [3:0]   in_id_i;
    logic         in_bypass_i, in_valid_i, in_ready_o;
    logic [31:0]  refill_req_addr_o;
    logic         refill_req_id_o, refill_req_bypass_o, refill_req_valid_o, refill_req_ready_i;
    logic [127:0] refill_rsp_data_i;
    logic         refill_rsp_error_i, refill_rsp_id_i, refill_rsp_bypass_i;
    logic         refill_rsp_valid_i, refill_rsp_ready_o;
    logic [27:0]  write_addr_o;
    logic [127:0] write_data_o;
    logic         write_error_o, write_valid_o, write_ready_i;
    logic [127:0] out_rsp_data_o;
    logic         out_rsp_error_o;
    logic [3:0]   out_rsp_id_o;
    logic         out_rsp_valid_o, out_rsp_ready_i;

    snitch_icache_miss_tracker #(.CFG(TB_CFG)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .in_addr_i           (in_addr_i),
        .in_id_i             (in_id_i),
        .in_bypass_i         (in_bypass_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .refill_req_addr_o   (refill_req_addr_o),
        .refill_req_id_o     (refill_req_id_o),
        .refill_req_bypass_o (refill_req_bypass_o),
        .refill_req_valid_o  (refill_req_valid_o),
        .refill_req_ready_i  (refill_req_ready_i),
        .refill_rsp_data_i   (refill_rsp_data_i),
        .refill_rsp_error_i  (refill_rsp_error_i),
        .refill_rsp_id_i     (refill_rsp_id_i),
        .refill_rsp_bypass_i (refill_rsp_bypass_i),
        .refill_rsp_valid_i  (refill_rsp_valid_i),
        .refill_rsp_ready_o  (refill_rsp_ready_o),
        .write_addr_o        (write_addr_o),
        .write_data_o        (write_data_o),
        .write_error_o       (write_error_o),
        .write_valid_o       (write_valid_o),
        .write_ready_i       (write_ready_i),
        .out_rsp_data_o      (out_rsp_data_o),
        .out_rsp_error_o     (out_rsp_error_o),
        .out_rsp_id_o        (out_rsp_id_o),
        .out_rsp_valid_o     (out_rsp_valid_o),
        .out_rsp_ready_i     (out_rsp_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        id;
        logic        byp;
    } req_t;

    typedef struct {
        logic [127:0] data;
        logic         err;
        logic [3:0]   mask;
        logic         wr;
        logic [27:0]  waddr;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    req_t req_e;
    rsp_t rsp_e;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    task automatic chk_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: every handshake pops the expectation pushed by the stimulus.
    always @(negedge clk) begin
        if (rst_n) begin
            if (refill_req_valid_o && refill_req_ready_i) begin
                if (req_q.size() == 0) begin
                    chk_val("req_unexpected", 128'd1, 128'd0);
                end else begin
                    req_e = req_q.pop_front();
                    chk_val("req_addr", refill_req_addr_o, req_e.addr);
                    chk_val("req_id", refill_req_id_o, req_e.id);
                    chk_val("req_bypass", refill_req_bypass_o, req_e.byp);
                end
            end
            if (out_rsp_valid_o && out_rsp_ready_i) begin
                if (rsp_q.size() == 0) begin
                    chk_val("rsp_unexpected", 128'd1, 128'd0);
                end else begin
                    rsp_e = rsp_q.pop_front();
                    chk_val("rsp_mask", out_rsp_id_o, rsp_e.mask);
                    chk_val("rsp_data", out_rsp_data_o, rsp_e.data);
                    chk_val("rsp_error", out_rsp_error_o, rsp_e.err);
                    chk_val("rsp_handshake", refill_rsp_ready_o, 1'b1);
                    chk_val("write_valid", write_valid_o, rsp_e.wr);
                    if (rsp_e.wr) begin
                        chk_val("write_addr", write_addr_o, rsp_e.waddr);
                        chk_val("write_data", write_data_o, rsp_e.data);
                        chk_val("write_error", write_error_o, rsp_e.err);
                    end
                end
            end else if (write_valid_o && write_ready_i) begin
                chk_val("write_without_rsp", 128'd1, 128'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_miss(input logic [31:0] a, input logic [3:0] id, input logic byp);
        in_addr_i   = a;
        in_id_i     = id;
        in_bypass_i = byp;
        in_valid_i  = 1'b1;
    endtask

    task automatic drive_rsp(input logic id, input logic [127:0] d, input logic e, input logic byp);
        refill_rsp_id_i     = id;
        refill_rsp_data_i   = d;
        refill_rsp_error_i  = e;
        refill_rsp_bypass_i = byp;
        refill_rsp_valid_i  = 1'b1;
    endtask

    task automatic exp_req(input logic [31:0] a, input logic id, input logic byp);
        req_q.push_back('{addr: a, id: id, byp: byp});
    endtask

    task automatic exp_rsp(input logic [127:0] d, input logic e, input logic [3:0] m,
                           input logic wr, input logic [27:0] wa);
        rsp_q.push_back('{data: d, err: e, mask: m, wr: wr, waddr: wa});
    endtask

    task automatic idle();
        in_valid_i         = 1'b0;
        refill_rsp_valid_i = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk_val({tag, "_req_valid"}, refill_req_valid_o, 1'b0);
        chk_val({tag, "_write_valid"}, write_valid_o, 1'b0);
        chk_val({tag, "_rsp_valid"}, out_rsp_valid_o, 1'b0);
    endtask

    logic [127:0] d_a, d_b, d_c;

    initial begin
        d_a = {4{32'hDEADBEEF}};
        d_b = {32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'h4B5A6978};
        d_c = {4{32'hA5A5_5A5A}};
        rst_n = 1'b0;
        in_addr_i = 32'h0; in_id_i = 4'h0; in_bypass_i = 1'b0; in_valid_i = 1'b0;
        refill_req_ready_i = 1'b1;
        refill_rsp_data_i = 128'h0; refill_rsp_error_i = 1'b0; refill_rsp_id_i = 1'b0;
        refill_rsp_bypass_i = 1'b0; refill_rsp_valid_i = 1'b0;
        write_ready_i = 1'b1; out_rsp_ready_i = 1'b1;
        #2;
        chk_quiet("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_quiet("idle");
        chk_val("idle_in_ready", in_ready_o, 1'b1);

        // Single miss, line-aligned refill, write plus single-port response.
        drive_miss(32'h1004, 4'b0001, 1'b0); exp_req(32'h1000, 1'b0, 1'b0);
        @(negedge clk); chk_val("s1_in_ready", in_ready_o, 1'b1);
        tick(); idle();
        drive_rsp(1'b0, d_a, 1'b0, 1'b0); exp_rsp(d_a, 1'b0, 4'b0001, 1'b1, 28'h100);
        tick(); idle();

        // Coalescing: second port hits the pending line, one refill, merged mask.
        drive_miss(32'h1004, 4'b0001, 1'b0); exp_req(32'h1000, 1'b0, 1'b0);
        tick();
        drive_miss(32'h100C, 4'b0100, 1'b0);
        @(negedge clk);
        chk_val("s2_hit_ready", in_ready_o, 1'b1);
        chk_val("s2_hit_no_req", refill_req_valid_o, 1'b0);
        tick(); idle();
        drive_rsp(1'b0, d_b, 1'b0, 1'b0); exp_rsp(d_b, 1'b0, 4'b0101, 1'b1, 28'h100);
        tick(); idle();

        // Table full: third miss held until an entry retires.
        drive_miss(32'h1000, 4'b0001, 1'b0); exp_req(32'h1000, 1'b0, 1'b0);
        tick();
        drive_miss(32'h2000, 4'b0010, 1'b0); exp_req(32'h2000, 1'b1, 1'b0);
        tick();
        drive_miss(32'h3000, 4'b0100, 1'b0);
        @(negedge clk);
        chk_val("s3_full_ready", in_ready_o, 1'b0);
        chk_val("s3_full_req", refill_req_valid_o, 1'b0);
        tick();
        drive_rsp(1'b0, d_c, 1'b0, 1'b0); exp_rsp(d_c, 1'b0, 4'b0001, 1'b1, 28'h100);
        @(negedge clk);
        chk_val("s3_freeing_ready", in_ready_o, 1'b0);
        chk_val("s3_freeing_req", refill_req_valid_o, 1'b0);
        tick(); refill_rsp_valid_i = 1'b0;
        exp_req(32'h3000, 1'b0, 1'b0);
        @(negedge clk); chk_val("s3_issue_ready", in_ready_o, 1'b1);
        tick(); idle();
        drive_rsp(1'b1, d_a, 1'b0, 1'b0); exp_rsp(d_a, 1'b0, 4'b0010, 1'b1, 28'h200);
        tick();
        drive_rsp(1'b0, d_b, 1'b0, 1'b0); exp_rsp(d_b, 1'b0, 4'b0100, 1'b1, 28'h300);
        tick(); idle();

        // Bypass fetches never coalesce and skip the cache write.
        drive_miss(32'h1004, 4'b0010, 1'b1); exp_req(32'h1004, 1'b0, 1'b1);
        tick();
        drive_miss(32'h1004, 4'b1000, 1'b1); exp_req(32'h1004, 1'b1, 1'b1);
        tick(); idle();
        drive_rsp(1'b0, d_c, 1'b0, 1'b1); exp_rsp(d_c, 1'b0, 4'b0010, 1'b0, 28'h0);
        @(negedge clk); chk_val("s4_no_write", write_valid_o, 1'b0);
        tick();
        drive_rsp(1'b1, d_a, 1'b0, 1'b1); exp_rsp(d_a, 1'b0, 4'b1000, 1'b0, 28'h0);
        tick(); idle();

        // Write back-pressure stalls the response; a hit to the retiring line reallocates.
        drive_miss(32'h1000, 4'b0001, 1'b0); exp_req(32'h1000, 1'b0, 1'b0);
        tick(); idle();
        write_ready_i = 1'b0;
        drive_rsp(1'b0, d_b, 1'b0, 1'b0);
        @(negedge clk);
        chk_val("s5_stall_rsp_valid", out_rsp_valid_o, 1'b0);
        chk_val("s5_stall_rsp_ready", refill_rsp_ready_o, 1'b0);
        tick();
        write_ready_i = 1'b1;
        exp_rsp(d_b, 1'b0, 4'b0001, 1'b1, 28'h100);
        drive_miss(32'h1000, 4'b0010, 1'b0); exp_req(32'h1000, 1'b1, 1'b0);
        @(negedge clk); chk_val("s5_realloc_ready", in_ready_o, 1'b1);
        tick(); idle();
        drive_rsp(1'b1, d_c, 1'b0, 1'b0); exp_rsp(d_c, 1'b0, 4'b0010, 1'b1, 28'h100);
        tick(); idle();

        // Error response still writes the line and flags both sides.
        drive_miss(32'h1000, 4'b1000, 1'b0); exp_req(32'h1000, 1'b0, 1'b0);
        tick(); idle();
        drive_rsp(1'b0, d_a, 1'b1, 1'b0); exp_rsp(d_a, 1'b1, 4'b1000, 1'b1, 28'h100);
        tick(); idle();

        // Reset with two refills outstanding drops them all.
        drive_miss(32'h2000, 4'b0001, 1'b0); exp_req(32'h2000, 1'b0, 1'b0);
        tick();
        drive_miss(32'h3000, 4'b0010, 1'b0); exp_req(32'h3000, 1'b1, 1'b0);
        tick(); idle();
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        drive_miss(32'h4000, 4'b0100, 1'b0); exp_req(32'h4000, 1'b0, 1'b0);
        tick();
        drive_miss(32'h5000, 4'b1000, 1'b0); exp_req(32'h5000, 1'b1, 1'b0);
        @(negedge clk); chk_val("post_reset_ready", in_ready_o, 1'b1);
        tick(); idle();
        drive_rsp(1'b0, d_b, 1'b0, 1'b0); exp_rsp(d_b, 1'b0, 4'b0100, 1'b1, 28'h400);
        tick();
        drive_rsp(1'b1, d_c, 1'b0, 1'b0); exp_rsp(d_c, 1'b0, 4'b1000, 1'b1, 28'h500);
        tick(); idle();
        tick();

        chk_val("req_q_drained", req_q.size(), 0);
        chk_val("rsp_q_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
